// File: rtl/mc_datapath.sv
`default_nettype none
// ===========================================================================
// mc_datapath : multicycle RV-style datapath (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Optional MC_DATAPATH_PERF_EN adds a 64-bit retired-instruction counter.
// Revision    : 1.0
// ===========================================================================
module mc_datapath #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic [XLEN-1:0] pc,
    output logic            trap
`ifdef MC_DATAPATH_PERF_EN
    ,
    output logic [63:0]     instret
`endif
);
    localparam logic [2:0]      LS_F3 = (XLEN == 64) ? 3'b011 : 3'b010;
    localparam logic [XLEN-1:0] FOUR  = XLEN'(4);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     ir_q;
    logic [XLEN-1:0] pc_q, pc_d, a_q, b_q, alu_q, imm_q, tgt_q;
    logic            trap_q;
    logic [XLEN-1:0] rf_q [32];

    logic [6:0] w_opc, w_f7;
    logic [2:0] w_f3;
    logic [4:0] w_rs1, w_rs2, w_rd;
    assign w_opc = ir_q[6:0];
    assign w_rd  = ir_q[11:7];
    assign w_f3  = ir_q[14:12];
    assign w_rs1 = ir_q[19:15];
    assign w_rs2 = ir_q[24:20];
    assign w_f7  = ir_q[31:25];

    logic w_is_r, w_is_addi, w_is_ld, w_is_st, w_is_beq, w_is_jal, w_legal;
    assign w_is_r    = (w_opc == 7'b0110011) &&
                       (((w_f7 == 7'b0000000) && (w_f3 inside {3'b000, 3'b010, 3'b110, 3'b111})) ||
                        ((w_f7 == 7'b0100000) && (w_f3 == 3'b000)));
    assign w_is_addi = (w_opc == 7'b0010011) && (w_f3 == 3'b000);
    assign w_is_ld   = (w_opc == 7'b0000011) && (w_f3 == LS_F3);
    assign w_is_st   = (w_opc == 7'b0100011) && (w_f3 == LS_F3);
    assign w_is_beq  = (w_opc == 7'b1100011) && (w_f3 == 3'b000);
    assign w_is_jal  = (w_opc == 7'b1101111);
    assign w_legal   = w_is_r | w_is_addi | w_is_ld | w_is_st | w_is_beq | w_is_jal;

    logic [XLEN-1:0] w_imm;
    always_comb begin
        case (w_opc)
            7'b0100011: w_imm = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            7'b1100011: w_imm = {{(XLEN-12){ir_q[31]}}, ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            7'b1101111: w_imm = {{(XLEN-20){ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
            default:    w_imm = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
        endcase
    end

    logic [XLEN-1:0] w_rs1_val, w_rs2_val, w_op2, w_alu;
    assign w_rs1_val = (w_rs1 == 5'd0) ? '0 : rf_q[w_rs1];
    assign w_rs2_val = (w_rs2 == 5'd0) ? '0 : rf_q[w_rs2];
    assign w_op2     = w_is_r ? b_q : imm_q;

    // Non-R instructions (addi, load/store address) all use A + imm.
    always_comb begin
        w_alu = a_q + w_op2;
        if (w_is_r) begin
            case ({w_f7[5], w_f3})
                4'b1000: w_alu = a_q - b_q;
                4'b0111: w_alu = a_q & b_q;
                4'b0110: w_alu = a_q | b_q;
                4'b0010: w_alu = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
                default: w_alu = a_q + b_q;
            endcase
        end
    end

    logic w_req, w_retire;
    always_comb begin
        state_d  = state_q;
        w_req    = 1'b0;
        mem_we   = 1'b0;
        mem_addr = pc_q;
        w_retire = 1'b0;
        case (state_q)
            S_FETCH: begin
                w_req = 1'b1;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: state_d = w_legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (w_is_ld || w_is_st) begin
                    state_d = S_MEM;
                end else if (w_is_beq || w_is_jal) begin
                    w_retire = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                w_req    = 1'b1;
                mem_we   = w_is_st;
                mem_addr = alu_q;
                if (mem_ready) begin
                    w_retire = w_is_st;
                    state_d  = w_is_st ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                w_retire = 1'b1;
                state_d  = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (w_retire) begin
            if ((w_is_beq && (a_q == b_q)) || w_is_jal) pc_d = tgt_q;
            else                                        pc_d = pc_q + FOUR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            trap_q <= 1'b0;
            ir_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            alu_q  <= '0;
            imm_q  <= '0;
            tgt_q  <= '0;
        end else begin
            pc_q <= pc_d;
            if ((state_q == S_FETCH) && mem_ready) ir_q <= mem_rdata[31:0];
            if (state_q == S_DECODE) begin
                a_q   <= w_rs1_val;
                b_q   <= w_rs2_val;
                imm_q <= w_imm;
                tgt_q <= pc_q + w_imm;
                if (!w_legal) trap_q <= 1'b1;
            end
            if (state_q == S_EXEC) alu_q <= w_alu;
            // Load data reuses ALUOut as the memory data register for WB.
            if ((state_q == S_MEM) && mem_ready && w_is_ld) alu_q <= mem_rdata;
        end
    end

    logic            w_rf_we;
    logic [XLEN-1:0] w_rf_wd;
    assign w_rf_we = ((state_q == S_EXEC) && w_is_jal) || (state_q == S_WB);
    assign w_rf_wd = w_is_jal ? (pc_q + FOUR) : alu_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (w_rf_we && (w_rd != 5'd0)) begin
            rf_q[w_rd] <= w_rf_wd;
        end
    end

`ifdef MC_DATAPATH_PERF_EN
    logic [63:0] instret_q;
    always_ff @(posedge clk) begin
        if (reset)         instret_q <= '0;
        else if (w_retire) instret_q <= instret_q + 64'd1;
    end
    assign instret = instret_q;
`endif

    assign mem_req   = w_req & ~reset;
    assign mem_wdata = b_q;
    assign pc        = pc_q;
    assign trap      = trap_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_datapath.sv
`default_nettype none
// ===========================================================================
// tb_mc_datapath : directed self-checking bench for mc_datapath (XLEN=64).
// Revision       : 1.0
// ===========================================================================
module tb_mc_datapath;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_ready = 1'b1;
    logic        mem_req, mem_we, trap;
    logic [63:0] mem_addr, mem_wdata, mem_rdata, pc;
`ifdef MC_DATAPATH_PERF_EN
    logic [63:0] instret;
`endif

    int          tests = 0;
    int          fails = 0;
    int          total = 0;
    logic [7:0]  pmem [256];
    logic [7:0]  dmem [256];
    logic [255:0] dval;
    logic [63:0] st_addr, st_data;
    logic [7:0]  ridx;

    mc_datapath #(.XLEN(64), .RESET_PC(64'd0)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .pc        (pc),
        .trap      (trap)
`ifdef MC_DATAPATH_PERF_EN
        ,
        .instret   (instret)
`endif
    );

    always #5 clk = ~clk;

    // Byte memory: stored bytes shadow the program image until the next reset.
    always_comb begin
        mem_rdata = '0;
        ridx      = '0;
        for (int i = 0; i < 8; i++) begin
            ridx = mem_addr[7:0] + 8'(i);
            mem_rdata[i*8 +: 8] = dval[ridx] ? dmem[ridx] : pmem[ridx];
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            dval <= '0;
        end else if (mem_req && mem_we && mem_ready) begin
            for (int i = 0; i < 8; i++) begin
                dmem[mem_addr[7:0] + 8'(i)] <= mem_wdata[i*8 +: 8];
                dval[mem_addr[7:0] + 8'(i)] <= 1'b1;
            end
            st_addr <= mem_addr;
            st_data <= mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        for (int i = 0; i < 256; i++) pmem[i] = 8'h00;
    endtask

    task automatic put(input int a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) pmem[a + i] = w[i*8 +: 8];
    endtask

    task automatic run_instr(input int stall, output int cyc);
        logic [63:0] pc0;
        pc0 = pc;
        cyc = 0;
        if (stall > 0) mem_ready = 1'b0;
        while ((pc === pc0) && (cyc < 40)) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc <= stall) begin
                chk("stall_mem_req", {63'd0, mem_req}, 64'd1);
                chk("stall_mem_addr", mem_addr, pc0);
            end
            if (cyc == stall) mem_ready = 1'b1;
        end
        mem_ready = 1'b1;
    endtask

    task automatic step(input string tag, input int stall, input int exp_cyc, input logic [63:0] exp_pc);
        int c;
        run_instr(stall, c);
        total = total + c;
        chk({tag, "_cycles"}, 64'(c), 64'(exp_cyc));
        chk({tag, "_pc"}, pc, exp_pc);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int reqs;
        // ---------------- program A: arithmetic, load/store, stall, jal
        clr();
        put(0,  32'h00500093); put(4,  32'h00700113); put(8,  32'h002081B3);
        put(12, 32'h00303423); put(16, 32'h00803203); put(20, 32'h00403823);
        put(24, 32'h402082B3); put(28, 32'h0012A333); put(32, 32'h0050A3B3);
        put(36, 32'h0020F433); put(40, 32'h0020E4B3); put(44, 32'h00300513);
        put(48, 32'h08503023); put(52, 32'h08603423); put(56, 32'h08703823);
        put(60, 32'h08803C23); put(64, 32'h0A903023); put(68, 32'h0AA03423);
        put(72, 32'h00900013); put(76, 32'h0A003823); put(80, 32'h008005EF);
        put(84, 32'h0000007F); put(88, 32'h0AB03C23);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc, 64'd0);
        chk("rst_trap", {63'd0, trap}, 64'd0);
        chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
        reset = 1'b0;
        #1;
        chk("fetch_req", {63'd0, mem_req}, 64'd1);
        chk("fetch_addr", mem_addr, 64'd0);
        chk("fetch_we", {63'd0, mem_we}, 64'd0);
        total = 0;
        step("addi_x1", 0, 4, 64'd4);
        step("addi_x2", 0, 4, 64'd8);
        step("add_x3", 0, 4, 64'd12);
        chk("three_instr_total_cycles", 64'(total), 64'd12);
        step("sd_x3", 0, 4, 64'd16);
        chk("sd_x3_addr", st_addr, 64'd8);
        chk("sd_x3_data", st_data, 64'd12);
        step("ld_x4", 0, 5, 64'd20);
        step("sd_x4", 0, 4, 64'd24);
        chk("sd_x4_addr", st_addr, 64'd16);
        chk("sd_x4_data", st_data, 64'd12);
        step("sub", 0, 4, 64'd28);
        step("slt_true", 0, 4, 64'd32);
        step("slt_false", 0, 4, 64'd36);
        step("and", 0, 4, 64'd40);
        step("or", 0, 4, 64'd44);
        step("addi_fetch_stall", 3, 7, 64'd48);
        step("sd_x5", 0, 4, 64'd52);
        chk("sub_result", st_data, 64'hFFFF_FFFF_FFFF_FFFE);
        step("sd_x6", 0, 4, 64'd56);
        chk("slt_neg_lt_pos", st_data, 64'd1);
        step("sd_x7", 0, 4, 64'd60);
        chk("slt_pos_lt_neg", st_data, 64'd0);
        step("sd_x8", 0, 4, 64'd64);
        chk("and_result", st_data, 64'd5);
        step("sd_x9", 0, 4, 64'd68);
        chk("or_result", st_data, 64'd7);
        step("sd_x10", 0, 4, 64'd72);
        chk("addi_x10_result", st_data, 64'd3);
        step("addi_x0", 0, 4, 64'd76);
        step("sd_x0", 0, 4, 64'd80);
        chk("x0_reads_zero", st_data, 64'd0);
        step("jal", 0, 3, 64'd88);
        step("sd_x11", 0, 4, 64'd92);
        chk("jal_link", st_data, 64'd84);
        chk("jal_link_addr", st_addr, 64'd184);
`ifdef MC_DATAPATH_PERF_EN
        chk("instret_prog_a", instret, 64'd22);
`endif

        // ---------------- program B: beq not taken / taken backwards
        reset = 1'b1;
        clr();
        put(0, 32'h00500093); put(4, 32'h00700113); put(8, 32'h00208463);
        put(12, 32'h00000013); put(16, 32'hFE108CE3);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        step("b_addi_x1", 0, 4, 64'd4);
        step("b_addi_x2", 0, 4, 64'd8);
        step("beq_not_taken_fwd", 0, 3, 64'd12);
        step("nop", 0, 4, 64'd16);
        step("beq_taken_back", 0, 3, 64'd8);

        // ---------------- program C: beq not taken at 16, then illegal opcode
        reset = 1'b1;
        clr();
        put(0, 32'h00500093); put(4, 32'h00000013); put(8, 32'h00000013);
        put(12, 32'h00000013); put(16, 32'hFE208CE3); put(20, 32'h0000007F);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        step("c_addi_x1", 0, 4, 64'd4);
        step("c_nop1", 0, 4, 64'd8);
        step("c_nop2", 0, 4, 64'd12);
        step("c_nop3", 0, 4, 64'd16);
        step("beq_not_taken_16", 0, 3, 64'd20);
        @(posedge clk);
        #1;
        chk("trap_clear_after_fetch", {63'd0, trap}, 64'd0);
        @(posedge clk);
        #1;
        chk("trap_set_after_decode", {63'd0, trap}, 64'd1);
        chk("trap_pc", pc, 64'd20);
        reqs = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (mem_req) reqs++;
        end
        chk("trap_no_mem_req", 64'(reqs), 64'd0);
        chk("trap_pc_frozen", pc, 64'd20);
        chk("trap_sticky", {63'd0, trap}, 64'd1);

        // ---------------- program D: reset while a load waits in MEM
        reset = 1'b1;
        clr();
        put(0, 32'h00803203); put(4, 32'h00403823);
        put(8, 32'h11223344); put(12, 32'h55667788);
        @(posedge clk);
        #1;
        chk("reset_clears_trap", {63'd0, trap}, 64'd0);
        chk("reset_pc_from_trap", pc, 64'd0);
        reset = 1'b0;
        #1;
        repeat (3) @(posedge clk);
        #1;
        chk("ld_mem_req", {63'd0, mem_req}, 64'd1);
        chk("ld_mem_we", {63'd0, mem_we}, 64'd0);
        chk("ld_mem_addr", mem_addr, 64'd8);
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("ld_wait_addr_stable", mem_addr, 64'd8);
        chk("ld_wait_req_stable", {63'd0, mem_req}, 64'd1);
        reset = 1'b1;
        #1;
        chk("req_low_in_reset", {63'd0, mem_req}, 64'd0);
        @(posedge clk);
        #1;
        chk("midload_reset_pc", pc, 64'd0);
        chk("midload_reset_req", {63'd0, mem_req}, 64'd0);
`ifdef MC_DATAPATH_PERF_EN
        chk("midload_reset_instret", instret, 64'd0);
`endif
        reset = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("restart_fetch_req", {63'd0, mem_req}, 64'd1);
        chk("restart_fetch_addr", mem_addr, 64'd0);
        step("d_ld_x4", 0, 5, 64'd4);
        step("d_sd_x4", 0, 4, 64'd8);
        chk("d_ld_data", st_data, 64'h5566_7788_1122_3344);
        chk("d_sd_addr", st_addr, 64'd16);
`ifdef MC_DATAPATH_PERF_EN
        chk("instret_after_restart", instret, 64'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_datapath.md
MC_DATAPATH -- requirements
Module: mc_datapath

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath and register width; legal values 32 and 64.
REQ-002 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port mem_req  output  1  memory access request.
REQ-006 SHALL have port mem_we  output  1  1 = store, 0 = fetch or load.
REQ-007 SHALL have port mem_addr  output  XLEN  byte address.
REQ-008 SHALL have port mem_wdata  output  XLEN  store data.
REQ-009 SHALL have port mem_rdata  input  XLEN  fetch or load data; fetch uses bits [31:0].
REQ-010 SHALL have port mem_ready  input  1  access completes in any cycle where mem_req and mem_ready are both 1.
REQ-011 SHALL have port pc  output  XLEN  PC of the instruction in flight.
REQ-012 SHALL have port trap  output  1  sticky illegal-instruction flag.

Function
REQ-013 SHALL implement a multicycle FSM with states FETCH, DECODE, EXEC, MEM, WB, TRAP.
REQ-014 SHALL support add, sub, and, or, slt, addi, beq, jal, plus load/store: ld/sd when XLEN=64, lw/sw when XLEN=32.
REQ-015 SHALL set a per-instruction cycle count, with zero memory wait, of: R-type/addi 4 (F,D,E,WB); load 5 (F,D,E,M,WB); store 4 (F,D,E,M); beq 3 and jal 3 (F,D,E).
REQ-016 FETCH SHALL drive mem_req=1, mem_we=0, mem_addr=pc, and hold all three stable until mem_ready=1; it then latches mem_rdata[31:0] into IR and goes to DECODE.
REQ-017 MEM SHALL hold mem_req, mem_we, mem_addr=ALUOut and mem_wdata=rs2 value stable until mem_ready=1; each wait cycle adds exactly one cycle.
REQ-018 mem_req SHALL be 0 in DECODE, EXEC, WB and TRAP.
REQ-019 DECODE SHALL latch rs1/rs2 values into A/B, sign-extend the immediate to XLEN, and compute branch target pc+imm.
REQ-020 SHALL update pc only at instruction completion: pc+4 by default; branch target when beq is taken (A==B); pc+imm for jal; all arithmetic modulo 2^XLEN, so wrap-around is silent.
REQ-021 jal SHALL write pc+4 to rd in EXEC.
REQ-022 slt SHALL be a signed XLEN comparison returning 1 or 0.
REQ-023 Register x0 SHALL read 0 and ignore writes; 32 registers of XLEN bits.
REQ-024 An unsupported opcode or funct in DECODE SHALL enter TRAP and set trap=1; TRAP SHALL be absorbing until reset, with no register or memory writes and pc frozen at the faulting instruction.

Reset
REQ-025 reset=1 at a clock edge SHALL force state=FETCH, pc=RESET_PC, trap=0, IR/A/B/ALUOut=0, and all registers x1..x31=0.
REQ-026 Reset SHALL take priority over every event, including mid-access; an outstanding access is abandoned and mem_req reads 0 only in cycles where reset is asserted, then FETCH restarts.

Configuration
REQ-027 With MC_DATAPATH_PERF_EN defined, SHALL add output instret (64 bits, reset 0), incremented by 1 on each completed instruction, wrapping at 2^64 and never incremented in TRAP.
REQ-028 Without MC_DATAPATH_PERF_EN, port instret and its counter SHALL be absent, with all other behaviour identical.

Verification
REQ-029 Reset, then addi x1,x0,5 / addi x2,x0,7 / add x3,x1,x2 with mem_ready tied 1 -> x3=12 after 12 cycles; pc=12.
REQ-030 mem_ready low for 3 cycles during a fetch -> mem_addr/mem_req stable for those cycles; instruction takes 7 cycles.
REQ-031 sd x3,8(x0) then ld x4,8(x0) on XLEN=64 -> store with mem_addr=8, mem_wdata=12, mem_we=1; x4=12; cycle counts 4 and 5.
REQ-032 beq x1,x1,-8 at pc=16 -> pc=8 after 3 cycles; beq not taken -> pc=20.
REQ-033 Opcode 0x7F -> trap=1 after DECODE, pc unchanged, no further mem_req; reset clears trap and pc=RESET_PC.
REQ-034 With MC_DATAPATH_PERF_EN defined, reset asserted mid-load (MEM state) -> instret=0, no register write, FETCH restarts at RESET_PC.
